booth_r4_seq_mult: RTL and testbench



---
 rtl/booth_r4_seq_mult.sv | 139 +++++++++++++
 tb/tb_booth_r4_seq_mult.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/booth_r4_seq_mult.sv
`default_nettype none
// =============================================================================
// Module   : booth_r4_seq_mult
// Purpose  : Iterative radix-4 Booth multiplier, DPC digits per cycle, valid/ready.
//            Optional macro BOOTH_R4_SEQ_MULT_EARLY_EXIT_EN ends BUSY once all
//            remaining digits are zero.
// Revision : 1.0 - initial release
// =============================================================================
module booth_r4_seq_mult #(
   parameter int A_BITS = 17,
   parameter int B_BITS = 17,
   parameter int DPC    = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_signed,
   input  logic [A_BITS-1:0]        in_a,
   input  logic [B_BITS-1:0]        in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [A_BITS+B_BITS-1:0] out_p
);

   localparam int NDIG   = (B_BITS + 2) / 2;
   localparam int NCYC   = (NDIG + DPC - 1) / DPC;
   localparam int P_BITS = A_BITS + B_BITS;
   // Multiplier shifter covers every digit slot of every cycle plus the overlap bit.
   localparam int BSH_W  = 2 * DPC * NCYC + 1;
   localparam int CNT_W  = (NCYC > 1) ? $clog2(NCYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [P_BITS-1:0]  r_acc;
   logic [P_BITS-1:0]  r_m;
   logic [P_BITS-1:0]  w_acc_nxt;
   logic [BSH_W-1:0]   r_bsh;
   logic [BSH_W-1:0]   w_bsh_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_accept;
   logic               w_last;
   logic               w_a_sx;
   logic               w_b_sx;

   // Arithmetic is modulo 2^P_BITS, which yields the exact truncated product.
   function automatic logic [P_BITS-1:0] booth_pp(input logic [2:0]        trip,
                                                  input logic [P_BITS-1:0] m);
      case (trip)
         3'b001, 3'b010: booth_pp = m;
         3'b011:         booth_pp = m << 1;
         3'b100:         booth_pp = ~(m << 1) + P_BITS'(1);
         3'b101, 3'b110: booth_pp = ~m + P_BITS'(1);
         default:        booth_pp = '0;
      endcase
   endfunction

   assign w_a_sx    = in_signed & in_a[A_BITS-1];
   assign w_b_sx    = in_signed & in_b[B_BITS-1];
   assign w_bsh_nxt = $signed(r_bsh) >>> (2 * DPC);
   assign out_p     = r_acc;

   // Slots past the padded multiplier see only sign copies and recode to 0.
   always_comb begin
      w_acc_nxt = r_acc;
      for (int j = 0; j < DPC; j++) begin
         w_acc_nxt = w_acc_nxt + booth_pp(r_bsh[2*j +: 3], r_m << (2 * j));
      end
   end

`ifdef BOOTH_R4_SEQ_MULT_EARLY_EXIT_EN
   assign w_last = (r_cnt == CNT_W'(NCYC - 1)) || (&w_bsh_nxt) || !(|w_bsh_nxt);
`else
   assign w_last = (r_cnt == CNT_W'(NCYC - 1));
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc <= '0;
         r_m   <= '0;
         r_bsh <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_m   <= {{B_BITS{w_a_sx}}, in_a};
         r_bsh <= {{(BSH_W - 1 - B_BITS){w_b_sx}}, in_b, 1'b0};
      end else if (r_state == S_BUSY) begin
         r_acc <= w_acc_nxt;
         r_cnt <= r_cnt + CNT_W'(1);
         r_m   <= r_m << (2 * DPC);
         r_bsh <= w_bsh_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_seq_mult.sv
`default_nettype none
// Directed bench for booth_r4_seq_mult: DPC=1 and DPC=4 instances driven in lockstep.
module tb_booth_r4_seq_mult;

`ifdef BOOTH_R4_SEQ_MULT_EARLY_EXIT_EN
   localparam int L1 = -1;
   localparam int L4 = -1;
`else
   localparam int L1 = 10;
   localparam int L4 = 4;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_signed = 1'b0;
   logic [16:0] in_a = '0;
   logic [16:0] in_b = '0;
   logic        out_ready = 1'b1;
   logic        in_ready1, out_valid1, in_ready4, out_valid4;
   logic [33:0] out_p1, out_p4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   booth_r4_seq_mult #(.A_BITS(17), .B_BITS(17), .DPC(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .in_signed(in_signed), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid1), .out_ready(out_ready), .out_p(out_p1));

   booth_r4_seq_mult #(.A_BITS(17), .B_BITS(17), .DPC(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
      .in_signed(in_signed), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid4), .out_ready(out_ready), .out_p(out_p4));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One operation on both instances; operands are scrambled right after accept.
   task automatic do_op(input logic sgn, input logic [16:0] a, input logic [16:0] b,
                        input logic [33:0] exp, input int lat1, input int lat4,
                        input string tag);
      int cyc;
      bit got1, got4;
      chk({tag, ".rdy"}, 64'({in_ready1, in_ready4}), 64'(2'b11));
      in_signed = sgn; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_signed = ~sgn; in_a = ~a; in_b = ~b;
      cyc = 1; got1 = 1'b0; got4 = 1'b0;
      while (!(got1 && got4) && cyc < 40) begin
         if (out_valid1 && !got1) begin
            got1 = 1'b1;
            chk({tag, ".p1"}, 64'(out_p1), 64'(exp));
            if (lat1 >= 0) chk({tag, ".lat1"}, 64'(cyc), 64'(lat1));
         end
         if (out_valid4 && !got4) begin
            got4 = 1'b1;
            chk({tag, ".p4"}, 64'(out_p4), 64'(exp));
            if (lat4 >= 0) chk({tag, ".lat4"}, 64'(cyc), 64'(lat4));
         end
         @(negedge clk);
         cyc++;
      end
      chk({tag, ".done"}, 64'({got1, got4}), 64'(2'b11));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst.state", 64'({in_ready1, out_valid1, in_ready4, out_valid4}), 64'(4'b1010));
      chk("rst.p", 64'({out_p1, out_p4}), 64'(0));
      reset = 1'b0;
      @(negedge clk);

      do_op(1'b0, 17'h1FFFF, 17'h1FFFF, 34'h3_FFFC_0001, L1, L4, "umax");
      do_op(1'b1, 17'h10000, 17'h10000, 34'h1_0000_0000, L1, L4, "smin2");
      do_op(1'b1, 17'h1FFFF, 17'h1FFFF, 34'h0_0000_0001, L1, L4, "sm1sq");
      do_op(1'b1, 17'h1FFFF, 17'h00005, 34'h3_FFFF_FFFB, L1, L4, "sm1x5");
      do_op(1'b0, 17'h1FFFF, 17'h00005, 34'h0_0009_FFFB, L1, L4, "umaxx5");
      do_op(1'b1, 17'h00005, 17'h1FFFE, 34'h3_FFFF_FFF6, L1, L4, "s5xm2");
      do_op(1'b1, 17'h0FFFF, 17'h10000, 34'h3_0001_0000, L1, L4, "smix");
      do_op(1'b0, 17'h12345, 17'h00100, 34'h0_0123_4500, L1, L4, "ushift");
      do_op(1'b0, 17'h00000, 17'h12345, 34'h0, L1, L4, "azero");
      do_op(1'b1, 17'h1ABCD, 17'h00000, 34'h0, L1, L4, "bzero");
`ifdef BOOTH_R4_SEQ_MULT_EARLY_EXIT_EN
      do_op(1'b0, 17'h00007, 17'h00003, 34'h15, 3, 2, "ee7x3");
      do_op(1'b0, 17'h00007, 17'h1FFFF, 34'h0_000D_FFF9, 10, 4, "eefull");
`else
      do_op(1'b0, 17'h00007, 17'h00003, 34'h15, L1, L4, "u7x3");
      do_op(1'b0, 17'h00007, 17'h1FFFF, 34'h0_000D_FFF9, L1, L4, "u7xmax");
`endif

      // Back-pressure: product must hold while out_ready stays low.
      in_signed = 1'b0; in_a = 17'h00ABC; in_b = 17'h00123; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; in_a = 17'h1FFFF; in_b = 17'h1FFFF;
      for (int k = 0; k < 40 && !out_valid1; k++) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk("hold.v", 64'({out_valid1, in_ready1, out_valid4, in_ready4}), 64'(4'b1010));
         chk("hold.p1", 64'(out_p1), 64'(34'hC33B4));
         @(negedge clk);
      end
      chk("hold.p4", 64'(out_p4), 64'(34'hC33B4));
      out_ready = 1'b1;
      @(negedge clk);
      chk("hold.rel", 64'({out_valid1, in_ready1, out_valid4, in_ready4}), 64'(4'b0101));

      // Asynchronous reset during the 4th BUSY cycle of the DPC=1 instance.
      in_signed = 1'b0; in_a = 17'h01234; in_b = 17'h05678; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid.busy", 64'(in_ready1), 64'(0));
      reset = 1'b1;
      #1;
      chk("arst.state", 64'({in_ready1, out_valid1, in_ready4, out_valid4}), 64'(4'b1010));
      chk("arst.p", 64'({out_p1, out_p4}), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_op(1'b0, 17'h00003, 17'h00005, 34'hF, L1, L4, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
